// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: clear-sweep FSM encoding and
// default geometry.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: walks every entry index once after a clear request,
// strobing the storage array to zero that entry each cycle.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_idx,
    output state_t            state
);

    localparam int DEPTH = 1 << ADDR_W;
    // One extra bit lets the counter reach DEPTH, marking completion without wrapping.
    localparam logic [ADDR_W:0] IDX_END = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sweep_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                sweep_we = 1'b1;
                idx_d    = idx_q + 1'b1;
                if (idx_d == IDX_END) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign clear_busy = (state_q == SWEEP);
    assign sweep_idx  = idx_q[ADDR_W-1:0];
    assign state      = state_q;

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with per-entry busy scoreboard and a
// hardware clear sweep. Optional write-to-read bypass: REGISTER_FILE_BYPASS_EN.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              clear_req,
    output logic              clear_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_idx;
    state_t            fsm_state;

    logic [DATA_W-1:0] rd_a_data, rd_b_data;
    logic              rd_a_busy, rd_b_busy;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .sweep_we   (sweep_we),
        .sweep_idx  (sweep_idx),
        .state      (fsm_state)
    );

    always_comb begin
        rd_a_data = mem[ra_addr];
        rd_b_data = mem[rb_addr];
        rd_a_busy = busy[ra_addr];
        rd_b_busy = busy[rb_addr];
`ifdef REGISTER_FILE_BYPASS_EN
        // Forward the in-flight write; busy reflects a coinciding claim to the same entry.
        if (wr_en && (ra_addr == wr_addr)) begin
            rd_a_data = wr_data;
            rd_a_busy = claim_en && (claim_addr == wr_addr);
        end
        if (wr_en && (rb_addr == wr_addr)) begin
            rd_b_data = wr_data;
            rd_b_busy = claim_en && (claim_addr == wr_addr);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy   <= '0;
            reg_a  <= '0;
            reg_b  <= '0;
            busy_a <= 1'b0;
            busy_b <= 1'b0;
        end else if (sweep_we) begin
            mem[sweep_idx]  <= '0;
            busy[sweep_idx] <= 1'b0;
        end else begin
            if (rd_en) begin
                reg_a  <= rd_a_data;
                reg_b  <= rd_b_data;
                busy_a <= rd_a_busy;
                busy_b <= rd_b_busy;
            end
            if (wr_en) begin
                mem[wr_addr]  <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            // Placed after the write so a same-entry claim leaves the entry busy.
            if (claim_en) begin
                busy[claim_addr] <= 1'b1;
            end
        end
    end

endmodule
